fetch_port_arbiter: RTL and testbench
=====================================

Name: fetch_port_arbiter

Overview:
Shares the single accelerator SRAM read port between the IFM and filter address streams produced by the address generator. Arbitrates per cycle with round-robin and registers the winning request onto the memory port. A tag FIFO records the source of each outstanding request, so in-order read responses are routed back to the IFM or filter data consumer. Sits between the address generator and the on-chip buffer memory controller.

Parameters:
ADDR_W, 32, request address width
DATA_W, 32, read data width
MAX_OUT, 4, maximum outstanding requests (power of 2, >=2); counts the output register plus requests in memory
CNT_W, 16, width of the per-requester grant counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ifm_req_valid  in  1  IFM address valid
ifm_req_addr  in  ADDR_W  IFM fetch address
ifm_req_ready  out  1  IFM request accepted this cycle
flt_req_valid  in  1  filter address valid
flt_req_addr  in  ADDR_W  filter fetch address
flt_req_ready  out  1  filter request accepted this cycle
mem_req_valid  out  1  memory read request valid (registered)
mem_req_addr  out  ADDR_W  memory read address (registered)
mem_req_ready  in  1  memory accepts request
mem_rsp_valid  in  1  read data valid, in request order
mem_rsp_data  in  DATA_W  read data
ifm_rsp_valid  out  1  routed IFM data valid
flt_rsp_valid  out  1  routed filter data valid
rsp_data  out  DATA_W  routed read data (shared)
clr_cnt  in  1  synchronous clear of grant counters and rsp_err
ifm_grant_cnt  out  CNT_W  IFM grants since reset/clear
flt_grant_cnt  out  CNT_W  filter grants since reset/clear
rsp_err  out  1  sticky: response arrived with no outstanding tag
idle  out  1  no request outstanding anywhere

Behaviour:
- Reset values: mem_req_valid=0, mem_req_addr=0, counters=0, rsp_err=0, tag FIFO empty, rr_ptr=IFM. idle=1. ifm_rsp_valid=flt_rsp_valid=0 while the FIFO is empty.
- Load condition: load = (!mem_req_valid || mem_req_ready) && (out_cnt < MAX_OUT || pop). pop = mem_rsp_valid && FIFO not empty. A pop frees its slot in the same cycle.
- Arbitration (combinational, same cycle):
  - Only one valid: that requester wins.
  - Both valid: the rr_ptr side wins.
  - After each grant, rr_ptr moves to the other requester.
  - If no request is valid, rr_ptr holds.
- ifm_req_ready = load && IFM wins. flt_req_ready likewise. Each ready is asserted only when the matching valid is high, and at most one ready is high per cycle.
- On grant in cycle N:
  - mem_req_valid/mem_req_addr update at N+1, giving 1-cycle request latency.
  - Source tag (0=IFM, 1=filter) is pushed into the FIFO at N+1.
  - Matching grant counter increments, wrapping modulo 2^CNT_W.
- Output register: if mem_req_ready with no new load, mem_req_valid drops to 0. While mem_req_valid && !mem_req_ready, address and valid hold stable.
- Response routing, combinational, zero latency:
  - rsp_data = mem_rsp_data.
  - ifm_rsp_valid = pop && head tag==IFM; flt_rsp_valid = pop && head tag==filter.
  - Consumers cannot backpressure.
- Spurious response: mem_rsp_valid with an empty FIFO sets rsp_err. The data is dropped and neither rsp_valid asserts.
- Simultaneous push and pop: legal at any occupancy, including full, and the count is unchanged.
- clr_cnt: zeroes both counters and rsp_err next cycle. It has priority over an increment in the same cycle.
- idle = (out_cnt == 0). out_cnt = FIFO occupancy, range 0..MAX_OUT.
- Reset mid-operation: all state is cleared at once. Responses to pre-reset requests that arrive after reset set rsp_err.

Decomposition:
- Package fetch_arb_pkg holds:
  - tag constants TAG_IFM=1'b0, TAG_FLT=1'b1;
  - localparam function for the FIFO pointer width, clog2(MAX_OUT).
- One sub-module: fetch_tag_fifo, a 1-bit-wide, MAX_OUT-deep synchronous FIFO with push/pop/full/empty/count and same-cycle push+pop on full.
- Arbitration, output register and counters stay in the top level.

Test Plan:
- IFM only, addr 0x100,0x104,0x108, mem_req_ready=1 -> mem_req_addr sequence appears one cycle after each grant; ifm_grant_cnt=3; flt_grant_cnt=0.
- Both valid every cycle (IFM 0x0+4k, filter 0x1000+4k), mem_req_ready=1, response latency 2 -> grants alternate IFM,filter,IFM,...; responses routed alternately ifm/flt; counters equal after 8 grants (4/4).
- mem_req_ready=0 for 5 cycles with both valid -> mem_req_addr holds; no further readys after the output register is full; grants resume alternating on release.
- MAX_OUT=4, no responses, both valid -> exactly 4 grants, then both readys=0 and idle=0. One mem_rsp_valid with mem_req_ready=1 -> a grant occurs in that same cycle.
- mem_rsp_valid asserted while idle=1 -> rsp_err=1, no rsp_valid. clr_cnt -> rsp_err=0 and counters=0 next cycle.
- Assert rst_n low with 3 outstanding, then deliver 3 responses -> all outputs at reset values, rsp_err=1, no routed rsp_valid.

Source files
------------

// File: rtl/fetch_arb_pkg.sv
// Shared constants and helpers for the fetch port arbiter and its tag FIFO.
// Tags record which requester owns each outstanding memory read.
package fetch_arb_pkg;

  localparam logic TAG_IFM = 1'b0;
  localparam logic TAG_FLT = 1'b1;

  // Pointer width for a FIFO of the given depth; never narrower than one bit.
  function automatic int fifo_ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fetch_port_arbiter_if.sv
// Request, memory and response bundle of the fetch port arbiter.
// slave is the arbiter's view; master is the surrounding system's view.
interface fetch_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              ifm_req_valid;
  logic [ADDR_W-1:0] ifm_req_addr;
  logic              ifm_req_ready;
  logic              flt_req_valid;
  logic [ADDR_W-1:0] flt_req_addr;
  logic              flt_req_ready;
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_ready;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              ifm_rsp_valid;
  logic              flt_rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  modport slave (
    input  ifm_req_valid, ifm_req_addr,
    output ifm_req_ready,
    input  flt_req_valid, flt_req_addr,
    output flt_req_ready,
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data,
    output ifm_rsp_valid, flt_rsp_valid, rsp_data
  );

  modport master (
    output ifm_req_valid, ifm_req_addr,
    input  ifm_req_ready,
    output flt_req_valid, flt_req_addr,
    input  flt_req_ready,
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data,
    input  ifm_rsp_valid, flt_rsp_valid, rsp_data
  );

endinterface

// File: rtl/fetch_tag_fifo.sv
// One-bit-wide source-tag FIFO; head is visible combinationally so responses
// can be routed in the cycle they arrive. Push while full is accepted with a pop.
module fetch_tag_fifo
  import fetch_arb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = fifo_ptr_w(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic           push_tag,
  input  logic           pop,
  output logic           head_tag,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] count
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [DEPTH-1:0] tag_mem;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push, do_pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == DEPTH_CNT);
  assign count    = count_reg;
  assign head_tag = tag_mem[rd_ptr_reg];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) tag_mem[wr_ptr_reg] <= push_tag;
  end

endmodule

// File: rtl/fetch_port_arbiter.sv
// Round-robin sharing of the SRAM read port between IFM and filter fetches,
// with tag-based in-order routing of read data back to the right consumer.
module fetch_port_arbiter
  import fetch_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_port_arbiter_if.slave  bus,
  input  logic                 clr_cnt,
  output logic [CNT_W-1:0]     ifm_grant_cnt,
  output logic [CNT_W-1:0]     flt_grant_cnt,
  output logic                 rsp_err,
  output logic                 idle
);

  localparam int PTR_W = fifo_ptr_w(MAX_OUT);

  logic              rr_ptr_reg, rr_ptr_next;
  logic              mem_valid_reg, mem_valid_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [CNT_W-1:0]  ifm_cnt_reg, ifm_cnt_next;
  logic [CNT_W-1:0]  flt_cnt_reg, flt_cnt_next;
  logic              rsp_err_reg, rsp_err_next;

  logic              ifm_win, flt_win, load, pop, grant_ifm, grant_flt;
  logic              fifo_head, fifo_full, fifo_empty;
  logic [PTR_W:0]    out_cnt;

  fetch_tag_fifo #(
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (grant_ifm || grant_flt),
    .push_tag (grant_flt ? TAG_FLT : TAG_IFM),
    .pop      (pop),
    .head_tag (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (out_cnt)
  );

  assign pop = bus.mem_rsp_valid && !fifo_empty;

  // A response retiring this cycle frees its slot for a same-cycle grant.
  always_comb begin
    ifm_win = 1'b0;
    flt_win = 1'b0;
    if (bus.ifm_req_valid && bus.flt_req_valid) begin
      if (rr_ptr_reg == TAG_IFM) ifm_win = 1'b1;
      else                       flt_win = 1'b1;
    end else begin
      ifm_win = bus.ifm_req_valid;
      flt_win = bus.flt_req_valid;
    end
    load      = (!mem_valid_reg || bus.mem_req_ready) && (!fifo_full || pop);
    grant_ifm = load && ifm_win;
    grant_flt = load && flt_win;
  end

  always_comb begin
    rr_ptr_next    = rr_ptr_reg;
    mem_valid_next = mem_valid_reg;
    mem_addr_next  = mem_addr_reg;
    ifm_cnt_next   = ifm_cnt_reg;
    flt_cnt_next   = flt_cnt_reg;
    rsp_err_next   = rsp_err_reg;

    if (grant_ifm) begin
      rr_ptr_next    = TAG_FLT;
      mem_valid_next = 1'b1;
      mem_addr_next  = bus.ifm_req_addr;
      ifm_cnt_next   = ifm_cnt_reg + CNT_W'(1);
    end else if (grant_flt) begin
      rr_ptr_next    = TAG_IFM;
      mem_valid_next = 1'b1;
      mem_addr_next  = bus.flt_req_addr;
      flt_cnt_next   = flt_cnt_reg + CNT_W'(1);
    end else if (bus.mem_req_ready) begin
      mem_valid_next = 1'b0;
    end

    if (bus.mem_rsp_valid && fifo_empty) rsp_err_next = 1'b1;

    if (clr_cnt) begin
      ifm_cnt_next = '0;
      flt_cnt_next = '0;
      rsp_err_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg    <= TAG_IFM;
      mem_valid_reg <= 1'b0;
      mem_addr_reg  <= '0;
      ifm_cnt_reg   <= '0;
      flt_cnt_reg   <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      rr_ptr_reg    <= rr_ptr_next;
      mem_valid_reg <= mem_valid_next;
      mem_addr_reg  <= mem_addr_next;
      ifm_cnt_reg   <= ifm_cnt_next;
      flt_cnt_reg   <= flt_cnt_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  assign bus.ifm_req_ready = grant_ifm;
  assign bus.flt_req_ready = grant_flt;
  assign bus.mem_req_valid = mem_valid_reg;
  assign bus.mem_req_addr  = mem_addr_reg;
  assign bus.ifm_rsp_valid = pop && (fifo_head == TAG_IFM);
  assign bus.flt_rsp_valid = pop && (fifo_head == TAG_FLT);
  assign bus.rsp_data      = DATA_W'(bus.mem_rsp_data);

  assign ifm_grant_cnt = ifm_cnt_reg;
  assign flt_grant_cnt = flt_cnt_reg;
  assign rsp_err       = rsp_err_reg;
  assign idle          = (out_cnt == '0);

endmodule

// File: tb/tb_fetch_port_arbiter.sv
// Directed bench for fetch_port_arbiter: a queue-based model is checked every
// cycle, and literal expectations pin the model at key points of each scenario.
module tb_fetch_port_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MAX_OUT = 4;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_cnt = 1'b0;
  logic [CNT_W-1:0] ifm_grant_cnt, flt_grant_cnt;
  logic rsp_err, idle;

  fetch_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fetch_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .clr_cnt       (clr_cnt),
    .ifm_grant_cnt (ifm_grant_cnt),
    .flt_grant_cnt (flt_grant_cnt),
    .rsp_err       (rsp_err),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int ifm_seen = 0;
  int flt_seen = 0;

  // Response source: automatic (2-cycle latency memory) or manual pulses.
  logic        rsp_auto = 1'b0;
  logic        auto_v = 1'b0, man_v = 1'b0, s0_v = 1'b0, acc = 1'b0;
  logic [31:0] auto_d = '0, man_d = '0, s0_d = '0, acc_d = '0;
  assign bus.mem_rsp_valid = rsp_auto ? auto_v : man_v;
  assign bus.mem_rsp_data  = rsp_auto ? auto_d : man_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          q[$];          // tags of outstanding requests, oldest first
  bit          m_valid = 0;
  logic [31:0] m_addr = '0;
  bit          m_pref_flt = 0; // requester favoured on the next contested cycle
  int          m_icnt = 0, m_fcnt = 0;
  bit          m_err = 0;

  function automatic void predict(output bit pop, output bit gi, output bit gf);
    bit room, port_free, want_i, want_f;
    pop       = bus.mem_rsp_valid && (q.size() > 0);
    room      = (q.size() < MAX_OUT) || pop;
    port_free = !m_valid || bus.mem_req_ready;
    want_i    = bus.ifm_req_valid;
    want_f    = bus.flt_req_valid;
    gi = 0;
    gf = 0;
    if (room && port_free) begin
      if (want_i && want_f) begin
        gf = m_pref_flt;
        gi = !m_pref_flt;
      end else begin
        gi = want_i;
        gf = want_f;
      end
    end
  endfunction

  initial begin : model_update
    bit pop, gi, gf, spur;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_valid = 0; m_addr = '0; m_pref_flt = 0;
        m_icnt = 0; m_fcnt = 0; m_err = 0;
      end else begin
        predict(pop, gi, gf);
        spur = bus.mem_rsp_valid && (q.size() == 0);
        if (pop) void'(q.pop_front());
        if (gi || gf) begin
          q.push_back(gf);
          m_valid = 1;
          m_addr = gi ? bus.ifm_req_addr : bus.flt_req_addr;
          if (gi) m_icnt = (m_icnt + 1) % (1 << CNT_W);
          else    m_fcnt = (m_fcnt + 1) % (1 << CNT_W);
          m_pref_flt = gi;
        end else if (bus.mem_req_ready) begin
          m_valid = 0;
        end
        if (spur) m_err = 1;
        if (clr_cnt) begin
          m_icnt = 0; m_fcnt = 0; m_err = 0;
        end
      end
    end
  end

  initial begin : compare
    bit pop, gi, gf;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        predict(pop, gi, gf);
        chk("ifm_req_ready", 32'(bus.ifm_req_ready), 32'(gi));
        chk("flt_req_ready", 32'(bus.flt_req_ready), 32'(gf));
        chk("mem_req_valid", 32'(bus.mem_req_valid), 32'(m_valid));
        chk("mem_req_addr", bus.mem_req_addr, m_addr);
        chk("ifm_rsp_valid", 32'(bus.ifm_rsp_valid), 32'(pop && q[0] == 1'b0));
        chk("flt_rsp_valid", 32'(bus.flt_rsp_valid), 32'(pop && q[0] == 1'b1));
        if (pop) chk("rsp_data", bus.rsp_data, bus.mem_rsp_data);
        chk("ifm_grant_cnt", 32'(ifm_grant_cnt), 32'(m_icnt));
        chk("flt_grant_cnt", 32'(flt_grant_cnt), 32'(m_fcnt));
        chk("rsp_err", 32'(rsp_err), 32'(m_err));
        chk("idle", 32'(idle), 32'(q.size() == 0));
        if (bus.ifm_rsp_valid) ifm_seen++;
        if (bus.flt_rsp_valid) flt_seen++;
      end
    end
  end

  // Memory returning data two cycles after each accepted request.
  initial begin : responder
    forever begin
      @(negedge clk);
      acc   = bus.mem_req_valid && bus.mem_req_ready && rst_n;
      acc_d = bus.mem_req_addr + 32'hA500_0000;
      @(posedge clk);
      #1;
      auto_v = s0_v; auto_d = s0_d;
      s0_v = acc;    s0_d = acc_d;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc();
    #2 rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  logic [31:0] ia, fa;
  logic [31:0] t1_addr [3] = '{32'h100, 32'h104, 32'h108};

  initial begin : stim
    bus.ifm_req_valid = 0; bus.ifm_req_addr = '0;
    bus.flt_req_valid = 0; bus.flt_req_addr = '0;
    bus.mem_req_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    neg();
    chk("reset_idle", 32'(idle), 32'd1);
    chk("reset_mem_valid", 32'(bus.mem_req_valid), 32'd0);

    // 1: IFM only
    rsp_auto = 1;
    cyc();
    bus.ifm_req_valid = 1;
    for (int k = 0; k < 3; k++) begin
      bus.ifm_req_addr = t1_addr[k];
      neg();
      chk("t1_ifm_ready", 32'(bus.ifm_req_ready), 32'd1);
      if (k > 0) chk("t1_addr", bus.mem_req_addr, t1_addr[k-1]);
      cyc();
    end
    bus.ifm_req_valid = 0;
    neg();
    chk("t1_last_addr", bus.mem_req_addr, 32'h108);
    chk("t1_ifm_cnt", 32'(ifm_grant_cnt), 32'd3);
    chk("t1_flt_cnt", 32'(flt_grant_cnt), 32'd0);
    repeat (6) cyc();

    // 2: both valid, alternating grants, routed responses
    do_reset();
    ifm_seen = 0; flt_seen = 0;
    ia = 32'h0; fa = 32'h1000;
    bus.ifm_req_valid = 1; bus.flt_req_valid = 1;
    for (int k = 0; k < 8; k++) begin
      bus.ifm_req_addr = ia; bus.flt_req_addr = fa;
      neg();
      chk("t2_ifm_ready", 32'(bus.ifm_req_ready), 32'(k % 2 == 0));
      chk("t2_flt_ready", 32'(bus.flt_req_ready), 32'(k % 2 == 1));
      if (k > 0)
        chk("t2_addr", bus.mem_req_addr,
            ((k - 1) % 2 == 0) ? 32'(4 * ((k - 1) / 2)) : 32'h1000 + 32'(4 * ((k - 1) / 2)));
      cyc();
      if (k % 2 == 0) ia += 4; else fa += 4;
    end
    bus.ifm_req_valid = 0; bus.flt_req_valid = 0;
    repeat (6) cyc();
    neg();
    chk("t2_ifm_cnt", 32'(ifm_grant_cnt), 32'd4);
    chk("t2_flt_cnt", 32'(flt_grant_cnt), 32'd4);
    chk("t2_ifm_rsps", 32'(ifm_seen), 32'd4);
    chk("t2_flt_rsps", 32'(flt_seen), 32'd4);

    // 3: memory backpressure
    cyc();
    bus.ifm_req_valid = 1; bus.flt_req_valid = 1;
    bus.ifm_req_addr = 32'h2000; bus.flt_req_addr = 32'h3000;
    neg();
    chk("t3_first_ifm", 32'(bus.ifm_req_ready), 32'd1);
    cyc();
    bus.mem_req_ready = 0;
    bus.ifm_req_addr = 32'h2004;
    for (int s = 0; s < 5; s++) begin
      neg();
      chk("t3_hold_valid", 32'(bus.mem_req_valid), 32'd1);
      chk("t3_hold_addr", bus.mem_req_addr, 32'h2000);
      chk("t3_no_ready", 32'({bus.ifm_req_ready, bus.flt_req_ready}), 32'd0);
      cyc();
      if (s == 4) bus.mem_req_ready = 1;
    end
    neg();
    chk("t3_resume_flt", 32'(bus.flt_req_ready), 32'd1);
    cyc();
    bus.flt_req_addr = 32'h3004;
    neg();
    chk("t3_resume_ifm", 32'(bus.ifm_req_ready), 32'd1);
    chk("t3_flt_addr", bus.mem_req_addr, 32'h3000);
    cyc();
    bus.ifm_req_valid = 0; bus.flt_req_valid = 0;
    repeat (6) cyc();

    // 4: outstanding limit, grant on the cycle a slot frees
    do_reset();
    rsp_auto = 0; man_v = 0;
    bus.ifm_req_valid = 1; bus.flt_req_valid = 1;
    for (int k = 0; k < 4; k++) begin
      neg();
      chk("t4_ifm_ready", 32'(bus.ifm_req_ready), 32'(k % 2 == 0));
      chk("t4_flt_ready", 32'(bus.flt_req_ready), 32'(k % 2 == 1));
      cyc();
    end
    for (int s = 0; s < 3; s++) begin
      neg();
      chk("t4_full_ready", 32'({bus.ifm_req_ready, bus.flt_req_ready}), 32'd0);
      chk("t4_full_idle", 32'(idle), 32'd0);
      cyc();
      if (s == 2) begin man_v = 1; man_d = 32'hDEAD_0001; end
    end
    neg();
    chk("t4_pop_ifm_rsp", 32'(bus.ifm_rsp_valid), 32'd1);
    chk("t4_pop_data", bus.rsp_data, 32'hDEAD_0001);
    chk("t4_pop_grant", 32'(bus.ifm_req_ready), 32'd1);
    cyc();
    man_v = 0;
    neg();
    chk("t4_refull", 32'({bus.ifm_req_ready, bus.flt_req_ready}), 32'd0);
    cyc();
    bus.ifm_req_valid = 0; bus.flt_req_valid = 0;
    for (int r = 0; r < 4; r++) begin
      man_v = 1; man_d = 32'h5000 + 32'(r);
      neg();
      cyc();
    end
    man_v = 0;
    neg();
    chk("t4_drained_idle", 32'(idle), 32'd1);

    // 5: spurious response and clear
    cyc();
    man_v = 1; man_d = 32'h0BAD;
    neg();
    chk("t5_no_rsp", 32'({bus.ifm_rsp_valid, bus.flt_rsp_valid}), 32'd0);
    cyc();
    man_v = 0;
    neg();
    chk("t5_rsp_err", 32'(rsp_err), 32'd1);
    chk("t5_ifm_cnt", 32'(ifm_grant_cnt), 32'd3);
    chk("t5_flt_cnt", 32'(flt_grant_cnt), 32'd2);
    cyc();
    clr_cnt = 1;
    neg();
    chk("t5_err_before_clr", 32'(rsp_err), 32'd1);
    cyc();
    clr_cnt = 0;
    neg();
    chk("t5_err_cleared", 32'(rsp_err), 32'd0);
    chk("t5_cnt_cleared", 32'({ifm_grant_cnt, flt_grant_cnt}), 32'd0);

    // 6: reset with outstanding requests, late responses
    cyc();
    bus.ifm_req_valid = 1;
    for (int k = 0; k < 3; k++) begin
      bus.ifm_req_addr = 32'h500 + 32'(4 * k);
      neg();
      chk("t6_ifm_ready", 32'(bus.ifm_req_ready), 32'd1);
      cyc();
    end
    bus.ifm_req_valid = 0;
    neg();
    chk("t6_busy", 32'(idle), 32'd0);
    chk("t6_ifm_cnt", 32'(ifm_grant_cnt), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_mem_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("t6_rst_mem_addr", bus.mem_req_addr, 32'd0);
    chk("t6_rst_cnt", 32'({ifm_grant_cnt, flt_grant_cnt}), 32'd0);
    chk("t6_rst_idle", 32'(idle), 32'd1);
    chk("t6_rst_err", 32'(rsp_err), 32'd0);
    cyc();
    rst_n = 1'b1;
    for (int r = 0; r < 3; r++) begin
      cyc();
      man_v = 1; man_d = 32'h77 + 32'(r);
      neg();
      chk("t6_late_no_rsp", 32'({bus.ifm_rsp_valid, bus.flt_rsp_valid}), 32'd0);
    end
    cyc();
    man_v = 0;
    neg();
    chk("t6_late_err", 32'(rsp_err), 32'd1);
    chk("t6_late_idle", 32'(idle), 32'd1);

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
